msd_iterative_core: RTL and testbench

//  Signed multi-cycle multiply / divide / square-root unit with one shared add/sub datapath.

---
 rtl/msd_iterative_core_pkg.sv | 25 ++
 rtl/msd_iterative_core_if.sv | 25 ++
 rtl/msd_iterative_core_addsub.sv | 11 +
 rtl/msd_iterative_core.sv | 188 ++++++++++++++++++
 tb/tb_msd_iterative_core.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/msd_iterative_core_pkg.sv
// Shared definitions for the iterative multiply/divide/sqrt core: opcodes, FSM states,
// and the error-result constant.
package msd_iterative_core_pkg;

  typedef enum logic [1:0] {
    OP_DIV     = 2'd0,
    OP_SQRT    = 2'd1,
    OP_MUL     = 2'd2,
    OP_ILLEGAL = 2'd3
  } msd_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_X,
    ST_LOAD_Y,
    ST_RUN,
    ST_DONE
  } msd_state_t;

  // All-ones pattern of width w (w <= 63); callers cast down to their word width.
  function automatic logic [63:0] err_result(input int unsigned w);
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/msd_iterative_core_if.sv
// Operand/result bus of the iterative core: master drives start/load/opcode/data,
// slave returns load requests, status and results.
interface msd_iterative_core_if #(parameter int W = 16);
  logic         start;
  logic         load;
  logic [1:0]   opcode;
  logic [W-1:0] data;
  logic         load_x;
  logic         load_y;
  logic         busy;
  logic [W-1:0] result;
  logic [W-1:0] residue;
  logic         ready_flag;
  logic         error_flag;

  modport master (
    output start, load, opcode, data,
    input  load_x, load_y, busy, result, residue, ready_flag, error_flag
  );

  modport slave (
    input  start, load, opcode, data,
    output load_x, load_y, busy, result, residue, ready_flag, error_flag
  );
endinterface

// File: rtl/msd_iterative_core_addsub.sv
// Plain unsigned add/subtract; the single arithmetic resource shared by all iterations.
module unsigned_adder_substracter #(
  parameter int WIDTH = 18
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum
);
  assign sum = sub ? (a - b) : (a + b);
endmodule

// File: rtl/msd_iterative_core.sv
// Signed multi-cycle mul/div/sqrt core on one shared W+2 add/sub datapath.
// Build option: define MSD_SATURATE_EN to saturate overflow instead of flagging an error.
module msd_iterative_core
  import msd_iterative_core_pkg::*;
#(
  parameter int WORD_LENGHT = 16
) (
  input logic                   clk,
  input logic                   rst,
  msd_iterative_core_if.slave   bus
);
  localparam int W  = WORD_LENGHT;
  localparam int AW = W + 2;
  localparam int CW = $clog2(W) + 1;
  localparam logic [W-1:0] ERR_RESULT = W'(err_result(W));
  localparam logic [W-1:0] POS_MAX    = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] NEG_MIN    = {1'b1, {(W-1){1'b0}}};

  function automatic logic [W-1:0] mag(input logic [W-1:0] v);
    return v[W-1] ? -v : v;
  endfunction

  msd_state_t    state, state_nxt;
  msd_op_t       op;
  logic [W-1:0]  acc, q, y;
  logic          sx, sy, err_pend;
  logic [CW-1:0] cnt, last_cnt;
  logic [W-1:0]  result_q, residue_q;
  logic          error_q;
  logic [AW-1:0] add_a, add_b, sum;
  logic          add_sub, ge, x_bad, y_bad;
  logic          neg, ovf, fin_err;
  logic [W-1:0]  mres, fin_res, fin_rsd;
  logic          load_x_c, load_y_c, busy_c, ready_c;

  assign last_cnt = (op == OP_SQRT) ? CW'(W/2 - 1) : CW'(W - 1);
  assign x_bad    = (op == OP_SQRT) && bus.data[W-1];
  assign y_bad    = (op == OP_DIV) && (bus.data == '0);
  assign ge       = ~sum[AW-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_x_c  = (state == ST_LOAD_X);
    load_y_c  = (state == ST_LOAD_Y);
    busy_c    = (state == ST_LOAD_X) || (state == ST_LOAD_Y) || (state == ST_RUN);
    ready_c   = (state == ST_DONE);
    if (bus.start) begin
      state_nxt = (msd_op_t'(bus.opcode) == OP_ILLEGAL) ? ST_DONE : ST_LOAD_X;
    end else begin
      case (state)
        ST_LOAD_X: if (bus.load) state_nxt = x_bad ? ST_DONE : ((op == OP_SQRT) ? ST_RUN : ST_LOAD_Y);
        ST_LOAD_Y: if (bus.load) state_nxt = y_bad ? ST_DONE : ST_RUN;
        ST_RUN:    if (cnt == last_cnt) state_nxt = ST_DONE;
        ST_DONE:   state_nxt = ST_IDLE;
        default:   ;
      endcase
    end
  end

  // Operand routing into the shared adder; each op keeps its partial state in acc/q/y.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_sub = 1'b0;
    case (op)
      OP_MUL:  begin add_a = {2'b00, acc}; add_b = q[0] ? {2'b00, y} : '0; end
      OP_DIV:  begin add_a = {1'b0, acc, q[W-1]}; add_b = {2'b00, y}; add_sub = 1'b1; end
      OP_SQRT: begin add_a = {acc, q[W-1:W-2]}; add_b = {y, 2'b01}; add_sub = 1'b1; end
      default: ;
    endcase
  end

  unsigned_adder_substracter #(.WIDTH(AW)) u_addsub (
    .a   (add_a),
    .b   (add_b),
    .sub (add_sub),
    .sum (sum)
  );

  // Sign fix-up and overflow/error selection from the finished magnitudes.
  always_comb begin
    neg     = sx ^ sy;
    ovf     = 1'b0;
    mres    = q;
    fin_rsd = '0;
    case (op)
      OP_MUL:  ovf = (acc != '0) || (neg ? (q > NEG_MIN) : q[W-1]);
      OP_DIV:  begin ovf = !neg && q[W-1]; fin_rsd = sx ? -acc : acc; end
      OP_SQRT: begin mres = y; fin_rsd = acc; end
      default: ;
    endcase
    fin_res = neg ? -mres : mres;
    fin_err = err_pend;
    if (err_pend) begin
      fin_res = ERR_RESULT;
      fin_rsd = '0;
    end else if (ovf) begin
`ifdef MSD_SATURATE_EN
      fin_res = neg ? NEG_MIN : POS_MAX;
      fin_rsd = '0;
`else
      fin_res = ERR_RESULT;
      fin_rsd = '0;
      fin_err = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op        <= OP_DIV;
      acc       <= '0;
      q         <= '0;
      y         <= '0;
      sx        <= 1'b0;
      sy        <= 1'b0;
      err_pend  <= 1'b0;
      cnt       <= '0;
      result_q  <= '0;
      residue_q <= '0;
      error_q   <= 1'b0;
    end else begin
      if (state == ST_DONE) begin
        result_q  <= fin_res;
        residue_q <= fin_rsd;
        error_q   <= fin_err;
      end
      if (bus.start) begin
        op       <= msd_op_t'(bus.opcode);
        error_q  <= 1'b0;
        err_pend <= (msd_op_t'(bus.opcode) == OP_ILLEGAL);
        cnt      <= '0;
      end else begin
        case (state)
          ST_LOAD_X: if (bus.load) begin
            sx       <= bus.data[W-1];
            sy       <= 1'b0;
            q        <= mag(bus.data);
            acc      <= '0;
            y        <= '0;
            err_pend <= x_bad;
          end
          ST_LOAD_Y: if (bus.load) begin
            sy       <= bus.data[W-1];
            err_pend <= y_bad;
            // mul: |X| becomes the multiplicand, |Y| the shifting multiplier
            if (op == OP_MUL) begin y <= q; q <= mag(bus.data); end
            else                    y <= mag(bus.data);
          end
          ST_RUN: begin
            cnt <= cnt + 1'b1;
            case (op)
              OP_MUL: begin
                acc <= sum[W:1];
                q   <= {sum[0], q[W-1:1]};
              end
              OP_DIV: begin
                if (ge) begin acc <= sum[W-1:0]; q <= {q[W-2:0], 1'b1}; end
                else    begin acc <= {acc[W-2:0], q[W-1]}; q <= {q[W-2:0], 1'b0}; end
              end
              OP_SQRT: begin
                q <= {q[W-3:0], 2'b00};
                if (ge) begin acc <= sum[W-1:0];   y <= {y[W-2:0], 1'b1}; end
                else    begin acc <= add_a[W-1:0]; y <= {y[W-2:0], 1'b0}; end
              end
              default: ;
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.load_x     = load_x_c;
  assign bus.load_y     = load_y_c;
  assign bus.busy       = busy_c;
  assign bus.ready_flag = ready_c;
  assign bus.result     = ready_c ? fin_res : result_q;
  assign bus.residue    = ready_c ? fin_rsd : residue_q;
  assign bus.error_flag = ready_c ? fin_err : error_q;

endmodule

// File: tb/tb_msd_iterative_core.sv
// Scoreboard bench for msd_iterative_core: directed cases plus random ops against an
// integer-arithmetic reference model.
module tb_msd_iterative_core;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  msd_iterative_core_if #(.W(W)) bus();
  msd_iterative_core #(.WORD_LENGHT(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] rsd;
    logic         err;
    int           stamp;
    int           lat;
    string        name;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
    end
  endtask

  // Reference: plain integer arithmetic on signed operands.
  function automatic exp_t model(input int op, input logic [W-1:0] xv, input logic [W-1:0] yv);
    exp_t   e;
    longint x  = $signed(xv);
    longint y  = $signed(yv);
    longint mx = (longint'(1) <<< (W-1)) - 1;
    longint mn = -(longint'(1) <<< (W-1));
    longint v  = 0;
    longint r  = 0;
    bit     ovf = 0;
    bit     err = 0;
    e.lat = W + 1;
    case (op)
      3: begin err = 1; e.lat = 1; end
      1: begin
        if (x < 0) begin err = 1; e.lat = 1; end
        else begin
          while ((v + 1) * (v + 1) <= x) v++;
          r = x - v * v;
          e.lat = W/2 + 1;
        end
      end
      0: begin
        if (y == 0) begin err = 1; e.lat = 1; end
        else begin v = x / y; r = x % y; ovf = (v > mx); end
      end
      default: begin v = x * y; ovf = (v > mx) || (v < mn); end
    endcase
    if (err) begin
      e.res = '1; e.rsd = '0; e.err = 1'b1;
    end else if (ovf) begin
`ifdef MSD_SATURATE_EN
      e.res = (v < 0) ? W'(mn) : W'(mx); e.rsd = '0; e.err = 1'b0;
`else
      e.res = '1; e.rsd = '0; e.err = 1'b1;
`endif
    end else begin
      e.res = W'(v); e.rsd = W'(r); e.err = 1'b0;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.ready_flag) begin
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_ready: ready_flag with result 0x%0h, none expected", bus.result);
      end else begin
        e = sbq.pop_front();
        chk({e.name, " result"},  bus.result,     e.res);
        chk({e.name, " residue"}, bus.residue,    e.rsd);
        chk({e.name, " error"},   bus.error_flag, e.err);
        chk({e.name, " latency"}, cyc - e.stamp,  e.lat);
      end
    end
  end

  task automatic begin_op(input int op, input int x, input int y, input bit push, input string nm);
    logic [W-1:0] xv = W'(x);
    logic [W-1:0] yv = W'(y);
    exp_t e = model(op, xv, yv);
    e.name = nm;
    @(negedge clk);
    bus.start = 1'b1; bus.opcode = op[1:0]; bus.load = 1'b0;
    if (op == 3 && push) begin e.stamp = cyc; sbq.push_back(e); end
    @(negedge clk);
    bus.start = 1'b0;
    if (op == 3) begin
      chk({nm, " no_load_x"}, bus.load_x, 0);
      return;
    end
    chk({nm, " load_x_after_start"}, bus.load_x, 1);
    bus.data = xv; bus.load = 1'b1;
    if (op == 1 && push) begin e.stamp = cyc; sbq.push_back(e); end
    @(negedge clk);
    bus.load = 1'b0;
    if (op == 1) return;
    chk({nm, " load_y"}, bus.load_y, 1);
    if (!bus.load_y) return;
    bus.data = yv; bus.load = 1'b1;
    if (push) begin e.stamp = cyc; sbq.push_back(e); end
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    int stray = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
      if (bus.load_x || bus.load_y) stray++;
    end
    chk({nm, " drained"}, sbq.size(), 0);
    chk({nm, " no_stray_load"}, stray, 0);
    sbq.delete();
  endtask

  task automatic run_op(input int op, input int x, input int y, input string nm);
    begin_op(op, x, y, 1'b1, nm);
    wait_done(nm);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int op, x, y;
    bus.start = 1'b0; bus.load = 1'b0; bus.opcode = 2'd0; bus.data = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset outputs",
        {bus.result, bus.residue, bus.ready_flag, bus.error_flag, bus.busy, bus.load_x, bus.load_y}, 0);
    rst = 1'b0;

    run_op(2, 7, -3, "mul_7x-3");
    run_op(0, -17, 5, "div_-17/5");
    run_op(1, 50, 0, "sqrt_50");
    run_op(0, 123, 0, "div_by_zero");
    run_op(3, 0, 0, "illegal_op");
    run_op(1, -4, 0, "sqrt_neg");
    run_op(2, 300, 200, "mul_ovf");
    run_op(2, -256, 128, "mul_min");
    run_op(0, -32768, -1, "div_ovf");
    run_op(0, -32768, 1, "div_min");
    run_op(1, 32767, 0, "sqrt_max");

    // abort: restart during RUN, old op must never report
    begin_op(2, 7, -3, 1'b0, "abort_old");
    repeat (5) @(negedge clk);
    run_op(0, 100, 7, "abort_new");

    // async reset during RUN
    begin_op(2, 123, 45, 1'b0, "rst_old");
    repeat (4) @(negedge clk);
    chk("rst_mid_run busy_before", bus.busy, 1);
    #2 rst = 1'b1;
    #1 chk("rst_mid_run outputs",
           {bus.result, bus.residue, bus.ready_flag, bus.error_flag, bus.busy, bus.load_x, bus.load_y}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (W + 4) @(negedge clk);
    run_op(0, 1000, -9, "after_rst");

    for (int i = 0; i < 40; i++) begin
      op = int'($urandom_range(0, 9));
      op = (op > 3) ? int'($urandom_range(0, 2)) : op;
      x = int'($urandom_range(0, 65535));
      y = int'($urandom_range(0, 65535));
      if ($urandom_range(0, 1) == 1) x = int'($urandom_range(0, 400)) - 200;
      if ($urandom_range(0, 1) == 1) y = int'($urandom_range(0, 40)) - 20;
      run_op(op, x, y, $sformatf("rand%0d_op%0d", i, op));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
